// File: rtl/multicycle_alu_if.sv
// Handshake and operand/result bundle for multicycle_alu.
// master drives operands and out_ready; slave is the ALU.
interface multicycle_alu_if #(
  parameter int unsigned XLEN = 64
) ();
  logic                in_valid;
  logic                in_ready;
  logic [XLEN-1:0]     A;
  logic [XLEN-1:0]     B;
  logic                Cin;
  logic [3:0]          ALUCtrl;
  logic                out_valid;
  logic                out_ready;
  logic [2*XLEN-1:0]   Result;
  logic                Zero;
  logic                Overflow;

  modport master (
    output in_valid, A, B, Cin, ALUCtrl, out_ready,
    input  in_ready, out_valid, Result, Zero, Overflow
  );

  modport slave (
    input  in_valid, A, B, Cin, ALUCtrl, out_ready,
    output in_ready, out_valid, Result, Zero, Overflow
  );
endinterface

// File: rtl/multicycle_alu.sv
// Valid/ready ALU: single-cycle AND/ADD/SUB/SLT, bit-serial signed MUL and DIV
// computed on operand magnitudes with a sign fix-up in the final BUSY cycle.
module multicycle_alu #(
  parameter int unsigned XLEN = 64
) (
  input logic             clk,
  input logic             rst,
  multicycle_alu_if.slave bus
);
  localparam int unsigned CntW = $clog2(XLEN + 1);
  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpDiv = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpMul = 4'b0011;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0]   res_q, res_d;
  logic                ovf_q, ovf_d;

  logic [XLEN-1:0]     sum, diff, a_in_mag, b_mag, quo_s, rem_s;
  logic [XLEN:0]       mul_sum, div_shift, div_sub;
  logic [2*XLEN-1:0]   prod, mul_res, div_res;
  logic                slt, div_ge, div_by_zero, div_ovf, out_valid;

  assign sum      = bus.A + bus.B + {{(XLEN-1){1'b0}}, bus.Cin};
  assign diff     = bus.A - bus.B;
  assign slt      = $signed(bus.A) < $signed(bus.B);
  assign a_in_mag = bus.A[XLEN-1] ? -bus.A : bus.A;
  assign b_mag    = b_q[XLEN-1] ? -b_q : b_q;

  // hi:lo is the product (MUL) or remainder:quotient-with-dividend (DIV).
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_mag} : '0);
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, b_mag};
  assign div_sub   = div_shift - {1'b0, b_mag};

  assign prod        = {hi_q, lo_q};
  assign mul_res     = (a_q[XLEN-1] ^ b_q[XLEN-1]) ? -prod : prod;
  assign quo_s       = (a_q[XLEN-1] ^ b_q[XLEN-1]) ? -lo_q : lo_q;
  assign rem_s       = a_q[XLEN-1] ? -hi_q : hi_q;
  assign div_by_zero = (b_q == '0);
  assign div_ovf     = (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
  assign div_res     = div_by_zero ? {a_q, {XLEN{1'b1}}} :
                       div_ovf     ? {{XLEN{1'b0}}, a_q} : {rem_s, quo_s};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          op_d    = bus.ALUCtrl;
          a_d     = bus.A;
          b_d     = bus.B;
          hi_d    = '0;
          lo_d    = a_in_mag;
          cnt_d   = '0;
          res_d   = '0;
          ovf_d   = 1'b0;
          state_d = StDone;
          case (bus.ALUCtrl)
            OpMul, OpDiv: state_d = StBusy;
            OpAnd: res_d = {{XLEN{1'b0}}, bus.A & bus.B};
            OpAdd: begin
              res_d = {{XLEN{sum[XLEN-1]}}, sum};
              ovf_d = (bus.A[XLEN-1] == bus.B[XLEN-1]) && (sum[XLEN-1] != bus.A[XLEN-1]);
            end
            OpSub: begin
              res_d = {{XLEN{diff[XLEN-1]}}, diff};
              ovf_d = (bus.A[XLEN-1] != bus.B[XLEN-1]) && (diff[XLEN-1] != bus.A[XLEN-1]);
            end
            OpSlt: res_d = {{(2*XLEN-1){1'b0}}, slt};
            default: ;
          endcase
        end
      end
      StBusy: begin
        if (cnt_q != CntW'(XLEN)) begin
          cnt_d = cnt_q + 1'b1;
          if (op_q == OpMul) begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
          end else begin
            hi_d = div_ge ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], div_ge};
          end
        end else begin
          // Extra cycle after the XLEN iterations applies signs and exceptions.
          state_d = StDone;
          res_d   = (op_q == OpMul) ? mul_res : div_res;
          ovf_d   = (op_q == OpDiv) && (div_by_zero || div_ovf);
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid    = (state_q == StDone);
  assign bus.out_valid = out_valid;
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.Result    = res_q;
  assign bus.Zero      = out_valid && (res_q == '0);
  assign bus.Overflow  = ovf_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed and randomized bench for multicycle_alu (XLEN=64) against a wide-integer
// reference model.
module tb_multicycle_alu;
  localparam int unsigned XLEN = 64;
  localparam longint LMAX = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam longint LMIN = -LMAX - 1;

  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  multicycle_alu_if #(.XLEN(XLEN)) bus ();
  multicycle_alu #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact wide-integer arithmetic, overflow as "true result out of range".
  function automatic void model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                input logic cin, output logic [127:0] res, output logic ovf,
                                output int lat);
    longint sa, sb, q, r;
    logic signed [127:0] wa, wb, full, wmax, wmin;
    sa = a; sb = b; wa = sa; wb = sb; wmax = LMAX; wmin = LMIN;
    res = '0; ovf = 1'b0; lat = 0;
    case (op)
      4'b0010: begin
        full = wa + wb + 128'(cin);
        ovf  = (full > wmax) || (full < wmin);
        res  = {{64{full[63]}}, full[63:0]};
      end
      4'b0110: begin
        full = wa - wb;
        ovf  = (full > wmax) || (full < wmin);
        res  = {{64{full[63]}}, full[63:0]};
      end
      4'b0011: begin
        full = wa * wb;
        res  = full;
        lat  = XLEN + 1;
      end
      4'b0001: begin
        lat = XLEN + 1;
        if (sb == 0) begin
          res = {a, 64'hFFFF_FFFF_FFFF_FFFF}; ovf = 1'b1;
        end else if (sa == LMIN && sb == -1) begin
          res = {64'd0, a}; ovf = 1'b1;
        end else begin
          q = sa / sb; r = sa % sb;
          res = {r, q};
        end
      end
      4'b0111: res = (sa < sb) ? 128'd1 : 128'd0;
      4'b0000: res = {64'd0, a & b};
      default: res = '0;
    endcase
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'(longint'($urandom_range(0, 40)) - 20);
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input int hold, input string tag);
    logic [127:0] er;
    logic eo;
    int el, lat;
    model(op, a, b, cin, er, eo, el);
    chk({tag, ":ready"}, 128'(bus.in_ready), 128'd1);
    bus.in_valid = 1'b1; bus.A = a; bus.B = b; bus.Cin = cin; bus.ALUCtrl = op;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the in-flight op must not see them.
    bus.in_valid = 1'b0; bus.A = {$urandom(), $urandom()}; bus.B = {$urandom(), $urandom()};
    bus.Cin = 1'($urandom()); bus.ALUCtrl = 4'($urandom());
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < XLEN + 20) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, ":latency"}, 128'(lat), 128'(el));
    chk({tag, ":result"}, bus.Result, er);
    chk({tag, ":zero"}, 128'(bus.Zero), 128'(er == 128'd0));
    chk({tag, ":ovf"}, 128'(bus.Overflow), 128'(eo));
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, ":hold_result"}, bus.Result, er);
      chk({tag, ":hold_flags"}, 128'({bus.out_valid, bus.in_ready, bus.Zero, bus.Overflow}),
          128'({1'b1, 1'b0, er == 128'd0, eo}));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, ":released"}, 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));
  endtask

  initial begin
    logic [3:0] op;
    logic seen;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.ALUCtrl = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("reset_outputs", 128'({bus.out_valid, bus.Zero, bus.Overflow}), 128'd0);
    chk("reset_result", bus.Result, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_ready", 128'(bus.in_ready), 128'd1);

    run_op(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0, "add_max_cin");
    run_op(4'b0011, -64'd3, 64'd5, 1'b0, 0, "mul_m3x5");
    run_op(4'b0001, -64'd7, 64'd2, 1'b0, 0, "div_m7d2");
    run_op(4'b0001, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 0, "div_by_zero");
    run_op(4'b0001, 64'h8000_0000_0000_0000, -64'd1, 1'b0, 0, "div_min_m1");
    run_op(4'b0110, 64'd5, 64'd5, 1'b0, 10, "sub_eq_hold");
    run_op(4'b0110, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 0, "sub_ovf");
    run_op(4'b0111, -64'd1, 64'd1, 1'b0, 0, "slt_true");
    run_op(4'b0000, 64'hF0F0_0000_FFFF_1234, 64'hFF00_FF00_0F0F_FFFF, 1'b0, 0, "and");
    run_op(4'b1010, 64'd9, 64'd9, 1'b1, 0, "undef");
    run_op(4'b0011, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 2, "mul_min_min");

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 6))
        0: op = 4'b0000;
        1: op = 4'b0001;
        2: op = 4'b0010;
        3: op = 4'b0011;
        4: op = 4'b0110;
        5: op = 4'b0111;
        default: op = 4'($urandom_range(8, 15));
      endcase
      run_op(op, rnd64(), rnd64(), 1'($urandom()), int'($urandom_range(0, 2)), "rand");
    end

    // Reset 30 cycles into a DIV: that result must never appear.
    bus.in_valid = 1'b1; bus.A = 64'd100; bus.B = 64'd7; bus.ALUCtrl = 4'b0001; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_outputs", 128'({bus.out_valid, bus.Zero, bus.Overflow}), 128'd0);
    chk("abort_result", bus.Result, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", 128'(bus.in_ready), 128'd1);
    seen = 1'b0;
    repeat (XLEN + 10) begin
      @(posedge clk); #1;
      seen = seen | bus.out_valid;
    end
    chk("abort_no_valid", 128'(seen), 128'd0);
    run_op(4'b0010, 64'd2, 64'd3, 1'b0, 0, "post_reset_add");
    chk("post_reset_add5", bus.Result, 128'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
